// File: rtl/serial_pkg.sv
// Shared encodings, FSM state types and oversampling constants for the
// serial command-channel bridge.
package serial_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int MID_TICK   = 8;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

   // 2'b11 is a second encoding of "no parity".
   function automatic logic par_enabled(input logic [1:0] p);
      return (p != PAR_NONE) && (p != 2'b11);
   endfunction

endpackage

// File: rtl/serial_fifo_iface_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers; a pop on
// an empty FIFO is ignored and a push on a full FIFO lands only with a pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, rd_q;
   logic             do_push, do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

endmodule

// File: rtl/serial_fifo_iface.sv
// UART bridge between the board serial pins and the cmdfifo_* byte-stream
// handshake: RX/TX FIFOs, runtime baud divisor, parity, 1/2 stop bits.
module serial_fifo_iface
   import serial_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int RX_DEPTH  = 16,
   parameter int TX_DEPTH  = 16,
   parameter int DIV_W     = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             rx_i,
   output logic             tx_o,
   input  logic [DIV_W-1:0] baud_div_i,
   input  logic [1:0]       parity_i,
   input  logic             stop2_i,
   output logic             cmdfifo_rxf,
   output logic [7:0]       cmdfifo_din,
   input  logic             cmdfifo_rd,
   output logic             cmdfifo_txe,
   input  logic             cmdfifo_wr,
   input  logic [7:0]       cmdfifo_dout,
   input  logic             err_clr_i,
   output logic             rx_parity_err,
   output logic             rx_frame_err,
   output logic             rx_overrun,
   output logic             tx_overflow,
   output logic             tx_busy
);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [3:0]    OS_LAST  = 4'(OVERSAMPLE - 1);
   localparam logic [3:0]    OS_MID   = 4'(MID_TICK);
   localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

   // ---------------- TX path ----------------
   tx_state_e            tx_state_q;
   logic [DIV_W-1:0]     tx_div_q, tx_cnt_q;
   logic [3:0]           tx_os_q;
   logic [DATA_BITS-1:0] tx_sh_q, tx_head;
   logic [BW-1:0]        tx_idx_q;
   logic [1:0]           tx_par_q;
   logic                 tx_par_bit_q, tx_stop2_q, tx_stop_idx_q, tx_q, tx_busy_q;
   logic                 tx_full, tx_empty, tx_pop, tx_bit_end;

   assign tx_pop     = (tx_state_q == TX_IDLE) && !tx_empty;
   assign tx_bit_end = (tx_cnt_q == tx_div_q) && (tx_os_q == OS_LAST);

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk_i   (clk_i),
      .rst_ni  (reset_i),
      .push_i  (cmdfifo_wr),
      .data_i  (cmdfifo_dout[DATA_BITS-1:0]),
      .pop_i   (tx_pop),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .head_o  (tx_head)
   );

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         tx_state_q    <= TX_IDLE;
         tx_q          <= 1'b1;
         tx_busy_q     <= 1'b0;
         tx_div_q      <= '0;
         tx_cnt_q      <= '0;
         tx_os_q       <= '0;
         tx_sh_q       <= '0;
         tx_idx_q      <= '0;
         tx_par_q      <= PAR_NONE;
         tx_par_bit_q  <= 1'b0;
         tx_stop2_q    <= 1'b0;
         tx_stop_idx_q <= 1'b0;
      end else begin
         // Bit-period counter restarts on every pop so the start bit is full length.
         if (tx_pop) begin
            tx_cnt_q <= '0;
            tx_os_q  <= '0;
         end else if (tx_cnt_q == tx_div_q) begin
            tx_cnt_q <= '0;
            tx_os_q  <= tx_os_q + 1'b1;
         end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
         end
         case (tx_state_q)
            TX_IDLE: if (!tx_empty) begin
               tx_state_q    <= TX_START;
               tx_q          <= 1'b0;
               tx_busy_q     <= 1'b1;
               tx_sh_q       <= tx_head;
               tx_div_q      <= baud_div_i;
               tx_par_q      <= parity_i;
               tx_stop2_q    <= stop2_i;
               tx_par_bit_q  <= (^tx_head) ^ (parity_i == PAR_ODD);
               tx_idx_q      <= '0;
               tx_stop_idx_q <= 1'b0;
            end
            TX_START: if (tx_bit_end) begin
               tx_state_q <= TX_DATA;
               tx_q       <= tx_sh_q[0];
            end
            TX_DATA: if (tx_bit_end) begin
               if (tx_idx_q == IDX_LAST) begin
                  if (par_enabled(tx_par_q)) begin
                     tx_state_q <= TX_PARITY;
                     tx_q       <= tx_par_bit_q;
                  end else begin
                     tx_state_q <= TX_STOP;
                     tx_q       <= 1'b1;
                  end
               end else begin
                  tx_idx_q <= tx_idx_q + 1'b1;
                  tx_sh_q  <= tx_sh_q >> 1;
                  tx_q     <= tx_sh_q[1];
               end
            end
            TX_PARITY: if (tx_bit_end) begin
               tx_state_q <= TX_STOP;
               tx_q       <= 1'b1;
            end
            TX_STOP: if (tx_bit_end) begin
               if (tx_stop2_q && !tx_stop_idx_q) begin
                  tx_stop_idx_q <= 1'b1;
               end else begin
                  tx_state_q <= TX_IDLE;
                  tx_busy_q  <= 1'b0;
               end
            end
            default: tx_state_q <= TX_IDLE;
         endcase
      end
   end

   assign tx_o        = tx_q;
   assign tx_busy     = tx_busy_q;
   assign cmdfifo_txe = !tx_full;

   // ---------------- RX path ----------------
   rx_state_e            rx_state_q;
   logic                 rx_meta_q, rx_sync_q, rx_prev_q;
   logic [DIV_W-1:0]     rx_div_q, rx_cnt_q;
   logic [3:0]           rx_os_q;
   logic [DATA_BITS-1:0] rx_sh_q, rx_head;
   logic [BW-1:0]        rx_idx_q;
   logic [1:0]           rx_par_q;
   logic                 rx_par_bit_q, rx_stop2_q, rx_stop_idx_q, rx_stop_bad_q;
   logic                 rx_full, rx_empty, rx_fall, rx_sample, rx_bit_end;
   logic                 rx_done, rx_par_bad, rx_frame_bad, rx_push;

   assign rx_fall      = rx_prev_q && !rx_sync_q;
   assign rx_sample    = (rx_cnt_q == '0) && (rx_os_q == OS_MID);
   assign rx_bit_end   = (rx_cnt_q == rx_div_q) && (rx_os_q == OS_LAST);
   // Frame completes at the mid-bit sample of the final stop bit.
   assign rx_done      = (rx_state_q == RX_STOP) && rx_sample && (!rx_stop2_q || rx_stop_idx_q);
   assign rx_par_bad   = par_enabled(rx_par_q) && ((^rx_sh_q) ^ rx_par_bit_q ^ (rx_par_q == PAR_ODD));
   assign rx_frame_bad = rx_stop_bad_q || !rx_sync_q;
   assign rx_push      = rx_done && !rx_par_bad && !rx_frame_bad;

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk_i   (clk_i),
      .rst_ni  (reset_i),
      .push_i  (rx_push),
      .data_i  (rx_sh_q),
      .pop_i   (cmdfifo_rd),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .head_o  (rx_head)
   );

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         rx_meta_q     <= 1'b1;
         rx_sync_q     <= 1'b1;
         rx_prev_q     <= 1'b1;
         rx_state_q    <= RX_IDLE;
         rx_div_q      <= '0;
         rx_cnt_q      <= '0;
         rx_os_q       <= '0;
         rx_sh_q       <= '0;
         rx_idx_q      <= '0;
         rx_par_q      <= PAR_NONE;
         rx_par_bit_q  <= 1'b0;
         rx_stop2_q    <= 1'b0;
         rx_stop_idx_q <= 1'b0;
         rx_stop_bad_q <= 1'b0;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         if (rx_state_q == RX_IDLE) begin
            rx_cnt_q <= '0;
            rx_os_q  <= '0;
         end else if (rx_cnt_q == rx_div_q) begin
            rx_cnt_q <= '0;
            rx_os_q  <= rx_os_q + 1'b1;
         end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
         end
         case (rx_state_q)
            RX_IDLE: if (rx_fall) begin
               rx_state_q    <= RX_START;
               rx_div_q      <= baud_div_i;
               rx_par_q      <= parity_i;
               rx_stop2_q    <= stop2_i;
               rx_idx_q      <= '0;
               rx_stop_idx_q <= 1'b0;
               rx_stop_bad_q <= 1'b0;
            end
            RX_START: begin
               if (rx_sample && rx_sync_q) rx_state_q <= RX_IDLE;
               else if (rx_bit_end)        rx_state_q <= RX_DATA;
            end
            RX_DATA: begin
               if (rx_sample) rx_sh_q <= {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
               if (rx_bit_end) begin
                  if (rx_idx_q == IDX_LAST)
                     rx_state_q <= par_enabled(rx_par_q) ? RX_PARITY : RX_STOP;
                  else
                     rx_idx_q <= rx_idx_q + 1'b1;
               end
            end
            RX_PARITY: begin
               if (rx_sample)  rx_par_bit_q <= rx_sync_q;
               if (rx_bit_end) rx_state_q   <= RX_STOP;
            end
            RX_STOP: begin
               if (rx_done) begin
                  rx_state_q <= RX_IDLE;
               end else begin
                  if (rx_sample)  rx_stop_bad_q <= rx_stop_bad_q || !rx_sync_q;
                  if (rx_bit_end) rx_stop_idx_q <= 1'b1;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   assign cmdfifo_rxf = !rx_empty;
   assign cmdfifo_din = rx_empty ? 8'h00 : 8'(rx_head);

   // ---------------- sticky error flags ----------------
   logic par_err_q, frame_err_q, overrun_q, overflow_q;
   logic par_err_d, frame_err_d, overrun_d, overflow_d;

   // A fresh error in the clear cycle wins over err_clr_i.
   always_comb begin
      par_err_d   = (par_err_q   && !err_clr_i) || (rx_done && rx_par_bad);
      frame_err_d = (frame_err_q && !err_clr_i) || (rx_done && rx_frame_bad);
      overrun_d   = (overrun_q   && !err_clr_i) || (rx_push && rx_full && !cmdfifo_rd);
      overflow_d  = (overflow_q  && !err_clr_i) || (cmdfifo_wr && tx_full && !tx_pop);
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         par_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         par_err_q   <= par_err_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         overflow_q  <= overflow_d;
      end
   end

   assign rx_parity_err = par_err_q;
   assign rx_frame_err  = frame_err_q;
   assign rx_overrun    = overrun_q;
   assign tx_overflow   = overflow_q;

endmodule

// File: tb/tb_serial_fifo_iface.sv
// Directed bench for serial_fifo_iface: received bytes are checked by a
// queue-based monitor; TX waveform and flags are checked against hand values.
module tb_serial_fifo_iface;
   logic        clk = 1'b0;
   logic        reset_i = 1'b0;
   logic        rx_drv = 1'b1;
   logic        loop = 1'b0;
   logic        rx_i, tx_o;
   logic [15:0] baud_div_i = '0;
   logic [1:0]  parity_i = 2'b00;
   logic        stop2_i = 1'b0;
   logic        cmdfifo_rxf, cmdfifo_txe, cmdfifo_rd, cmdfifo_wr = 1'b0;
   logic [7:0]  cmdfifo_din, cmdfifo_dout = '0;
   logic        err_clr_i = 1'b0;
   logic        rx_parity_err, rx_frame_err, rx_overrun, tx_overflow, tx_busy;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   bit          auto_rd = 1'b0;

   always #5 clk = ~clk;
   assign rx_i = loop ? tx_o : rx_drv;

   serial_fifo_iface #(.DATA_BITS(8), .RX_DEPTH(4), .TX_DEPTH(16), .DIV_W(16)) dut (
      .clk_i(clk), .reset_i(reset_i), .rx_i(rx_i), .tx_o(tx_o),
      .baud_div_i(baud_div_i), .parity_i(parity_i), .stop2_i(stop2_i),
      .cmdfifo_rxf(cmdfifo_rxf), .cmdfifo_din(cmdfifo_din), .cmdfifo_rd(cmdfifo_rd),
      .cmdfifo_txe(cmdfifo_txe), .cmdfifo_wr(cmdfifo_wr), .cmdfifo_dout(cmdfifo_dout),
      .err_clr_i(err_clr_i), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
      .rx_overrun(rx_overrun), .tx_overflow(tx_overflow), .tx_busy(tx_busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // RX monitor: pops the head whenever reading is enabled and compares it.
   initial begin
      cmdfifo_rd = 1'b0;
      forever begin
         @(negedge clk);
         cmdfifo_rd = 1'b0;
         if (auto_rd && cmdfifo_rxf) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rx_unexpected actual=%0h required=none", cmdfifo_din);
            end else begin
               chk("rx_byte", {24'h0, cmdfifo_din}, {24'h0, exp_q.pop_front()});
            end
            cmdfifo_rd = 1'b1;
         end
      end
   end

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cyc(1);
         n++;
      end
      chk("rx_drain_left", exp_q.size(), 0);
   endtask

   task automatic wait_tx_idle(input int budget);
      int n = 0;
      cyc(2);
      while (tx_busy && n < budget) begin
         cyc(1);
         n++;
      end
      chk("tx_idle", {31'h0, tx_busy}, 0);
   endtask

   // Drives one 8-bit frame on rx_drv at 16 cycles per bit (baud_div_i = 0).
   task automatic send_frame(input logic [7:0] d, input bit use_par, input logic pbit,
                             input logic stopv);
      rx_drv = 1'b0;
      cyc(16);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         cyc(16);
      end
      if (use_par) begin
         rx_drv = pbit;
         cyc(16);
      end
      rx_drv = stopv;
      cyc(16);
      rx_drv = 1'b1;
      cyc(32);
   endtask

   task automatic pulse_clr();
      err_clr_i = 1'b1;
      cyc(1);
      err_clr_i = 1'b0;
      cyc(1);
   endtask

   initial begin
      logic [7:0] a5;
      logic       exp_tx;
      logic       exp_busy;
      a5 = 8'hA5;

      // Reset
      cyc(5);
      chk("rst_tx_o", {31'h0, tx_o}, 1);
      chk("rst_txe", {31'h0, cmdfifo_txe}, 1);
      chk("rst_rxf", {31'h0, cmdfifo_rxf}, 0);
      chk("rst_din", {24'h0, cmdfifo_din}, 0);
      chk("rst_busy", {31'h0, tx_busy}, 0);
      chk("rst_flags", {28'h0, rx_parity_err, rx_frame_err, rx_overrun, tx_overflow}, 0);
      reset_i = 1'b1;
      cyc(3);

      // TX 0xA5 8N1, div 0: write in cycle 0, compare every cycle 1..162
      cmdfifo_wr = 1'b1;
      cmdfifo_dout = a5;
      cyc(1);
      cmdfifo_wr = 1'b0;
      chk("a5_tx_c1", {31'h0, tx_o}, 1);
      chk("a5_busy_c1", {31'h0, tx_busy}, 0);
      for (int k = 2; k <= 162; k++) begin
         cyc(1);
         if (k <= 17)       exp_tx = 1'b0;
         else if (k <= 145) exp_tx = a5[(k - 18) / 16];
         else               exp_tx = 1'b1;
         exp_busy = (k <= 161);
         if (tx_o !== exp_tx || tx_busy !== exp_busy)
            $display("  at cycle %0d", k);
         chk("a5_tx_o", {31'h0, tx_o}, {31'h0, exp_tx});
         chk("a5_busy", {31'h0, tx_busy}, {31'h0, exp_busy});
      end
      cyc(4);

      // Loopback: even parity, two stop bits, div 3
      parity_i = 2'b10;
      stop2_i = 1'b1;
      baud_div_i = 16'd3;
      loop = 1'b1;
      auto_rd = 1'b1;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h5A);
      cmdfifo_wr = 1'b1;
      cmdfifo_dout = 8'h00;
      cyc(1);
      cmdfifo_dout = 8'hFF;
      cyc(1);
      cmdfifo_dout = 8'h5A;
      cyc(1);
      cmdfifo_wr = 1'b0;
      wait_drain(6000);
      wait_tx_idle(2000);
      chk("loop_flags", {28'h0, rx_parity_err, rx_frame_err, rx_overrun, tx_overflow}, 0);
      loop = 1'b0;
      cyc(4);

      // RX overrun with depth 4, 8N1 at div 0
      parity_i = 2'b00;
      stop2_i = 1'b0;
      baud_div_i = 16'd0;
      auto_rd = 1'b0;
      send_frame(8'h11, 0, 0, 1);
      send_frame(8'h22, 0, 0, 1);
      send_frame(8'h33, 0, 0, 1);
      send_frame(8'h44, 0, 0, 1);
      chk("ovr_before", {31'h0, rx_overrun}, 0);
      send_frame(8'h55, 0, 0, 1);
      chk("ovr_set", {31'h0, rx_overrun}, 1);
      chk("ovr_rxf", {31'h0, cmdfifo_rxf}, 1);
      chk("ovr_head", {24'h0, cmdfifo_din}, 32'h11);
      chk("ovr_other", {29'h0, rx_parity_err, rx_frame_err, tx_overflow}, 0);
      pulse_clr();
      chk("ovr_clr", {31'h0, rx_overrun}, 0);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h44);
      auto_rd = 1'b1;
      wait_drain(200);
      cyc(4);
      chk("ovr_drained", {31'h0, cmdfifo_rxf}, 0);

      // Odd parity: 0x01 with parity 1 is bad, 0x03 with parity 1 is good
      parity_i = 2'b01;
      send_frame(8'h01, 1, 1'b1, 1'b1);
      chk("par_err_set", {31'h0, rx_parity_err}, 1);
      chk("par_no_push", {31'h0, cmdfifo_rxf}, 0);
      exp_q.push_back(8'h03);
      send_frame(8'h03, 1, 1'b1, 1'b1);
      wait_drain(200);
      chk("par_frame_ok", {31'h0, rx_frame_err}, 0);
      pulse_clr();
      chk("par_err_clr", {31'h0, rx_parity_err}, 0);

      // Stop bit sampled low
      parity_i = 2'b00;
      send_frame(8'h42, 0, 0, 1'b0);
      chk("frame_err_set", {31'h0, rx_frame_err}, 1);
      chk("frame_par_clr", {31'h0, rx_parity_err}, 0);
      chk("frame_no_push", {31'h0, cmdfifo_rxf}, 0);
      pulse_clr();
      chk("frame_err_clr", {31'h0, rx_frame_err}, 0);

      // TX overflow: 18 back-to-back writes from idle, delivered via loopback
      loop = 1'b1;
      for (int k = 0; k < 17; k++) exp_q.push_back(8'h30 + 8'(k));
      for (int k = 0; k < 18; k++) begin
         chk("ovf_txe", {31'h0, cmdfifo_txe}, (k <= 16) ? 32'd1 : 32'd0);
         cmdfifo_wr = 1'b1;
         cmdfifo_dout = 8'h30 + 8'(k);
         cyc(1);
      end
      cmdfifo_wr = 1'b0;
      chk("ovf_set", {31'h0, tx_overflow}, 1);
      chk("ovf_txe_end", {31'h0, cmdfifo_txe}, 0);
      wait_drain(5000);
      wait_tx_idle(500);
      cyc(200);
      chk("ovf_rx_flags", {29'h0, rx_parity_err, rx_frame_err, rx_overrun}, 0);
      pulse_clr();
      chk("ovf_clr", {31'h0, tx_overflow}, 0);

      // Reset mid-frame drives tx_o high without a clock edge
      loop = 1'b0;
      cmdfifo_wr = 1'b1;
      cmdfifo_dout = 8'h00;
      cyc(1);
      cmdfifo_wr = 1'b0;
      cyc(20);
      chk("mid_tx_low", {31'h0, tx_o}, 0);
      reset_i = 1'b0;
      #1;
      chk("mid_rst_tx_o", {31'h0, tx_o}, 1);
      chk("mid_rst_busy", {31'h0, tx_busy}, 0);
      chk("mid_rst_txe", {31'h0, cmdfifo_txe}, 1);
      cyc(2);
      reset_i = 1'b1;
      cyc(40);
      chk("post_rst_tx_o", {31'h0, tx_o}, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_fifo_iface.md
# serial_fifo_iface

Parametrised UART command-channel bridge and successor to the single-byte serial register interface. It keeps the `cmdfifo_*` byte-stream handshake, so the register/command decoder connects unchanged. It adds RX and TX FIFOs, a runtime baud divisor, configurable parity and stop bits, and sticky error reporting. It sits between the board serial pins and the command decoder.

## Interface
- `DATA_BITS`, 8: payload bits per frame, 5..8; the unused upper bits of `cmdfifo_din` read 0.
- `RX_DEPTH`, 16: RX FIFO entries, power of 2, ≥2.
- `TX_DEPTH`, 16: TX FIFO entries, power of 2, ≥2.
- `DIV_W`, 16: width of `baud_div_i`.
- `clk_i` in 1: single clock; all logic is on the rising edge.
- `reset_i` in 1: reset, asynchronous and active-low.
- `rx_i` in 1: serial input, asynchronous to `clk_i`.
- `tx_o` out 1: serial output, idle high.
- `baud_div_i` in `DIV_W`: oversample tick period minus 1; one bit time = 16·(`baud_div_i`+1) clocks.
- `parity_i` in 2: 00 none, 01 odd, 10 even, 11 none.
- `stop2_i` in 1: 1 selects two stop bits for TX and checks both on RX.
- `cmdfifo_rxf` out 1: RX FIFO non-empty.
- `cmdfifo_din` out 8: RX FIFO head, first-word-fall-through.
- `cmdfifo_rd` in 1: pop the RX head.
- `cmdfifo_txe` out 1: TX FIFO not full.
- `cmdfifo_wr` in 1: push `cmdfifo_dout`.
- `cmdfifo_dout` in 8: TX byte; only the low `DATA_BITS` bits are sent.
- `err_clr_i` in 1: clears all sticky error flags.
- `rx_parity_err`, `rx_frame_err`, `rx_overrun`, `tx_overflow` out 1 each: sticky error flags.
- `tx_busy` out 1: TX FSM not in IDLE.

## Operation
- Reset values: `tx_o`=1, `cmdfifo_rxf`=0, `cmdfifo_din`=0, `cmdfifo_txe`=1, `tx_busy`=0, all error flags 0. Both FIFOs are empty and both FSMs are in IDLE.
- Reset asserted mid-frame aborts the frame immediately; `tx_o` goes high asynchronously.
- `baud_div_i`, `parity_i` and `stop2_i` are latched per direction at frame start. Changes mid-frame take effect on the next frame.
- Frame format: start bit (0), data bits LSB first, optional parity bit, 1 or 2 stop bits (1).
- TX FSM states: IDLE → START → DATA (`DATA_BITS` bits) → PARITY (skipped if none) → STOP (1 or 2 bits) → IDLE.
  - In IDLE with the TX FIFO non-empty, the FSM pops one byte and enters START.
  - TX uses its own 16·(div+1) bit-period counter, cleared on pop.
- RX input path: `rx_i` passes through a 2-FF synchroniser. A per-direction tick counter runs at (div+1) clocks per tick, giving 16 ticks per bit.
- RX FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE waits for a synchronised falling edge.
  - START re-samples at tick 8. If the line is high, the start is false and the FSM returns to IDLE with no flag set.
  - All later bits are sampled at tick 8 of their bit.
- RX completion at the end of the last stop-bit sample:
  - Parity mismatch: byte discarded, `rx_parity_err` set.
  - Any stop bit sampled 0: byte discarded, `rx_frame_err` set. If both faults occur, both flags are set.
  - Otherwise the byte is pushed. If the RX FIFO is full and there is no same-cycle pop, the byte is dropped and `rx_overrun` is set.
- `cmdfifo_rd` while empty is ignored. `cmdfifo_wr` while `cmdfifo_txe`=0 drops the byte and sets `tx_overflow`.
- Simultaneous push and pop on a full FIFO both take effect: count is unchanged, no error. The same holds on an empty FIFO with FWFT bypass disallowed: the push lands and the pop is ignored.
- `err_clr_i` clears the flags on the next edge. A new error in the same cycle wins, so the flag stays 1.
- FIFO pointers are `$clog2(DEPTH)`+1 bits wide with wrap-bit full/empty detection.

## Timing
- `cmdfifo_wr` at cycle 0 with the TX FSM idle:
  - FIFO non-empty at cycle 1, popped at cycle 1.
  - `tx_o` low from cycle 2.
- `tx_busy` rises at cycle 2 and falls when the last stop bit ends.
- Back-to-back frames: the next start bit follows the last stop bit after exactly 1 idle cycle (IDLE pop cycle).
- `cmdfifo_txe` updates 1 cycle after the push or pop that changes fullness.
- RX: `cmdfifo_rxf` rises 1 cycle after the final stop-bit sample. `cmdfifo_din` is valid in the same cycle.
- After a pop, `cmdfifo_din` presents the next entry 1 cycle later.
- RX input latency: 2 cycles from the synchroniser plus the tick-8 sampling offset.

## Structure
- Package `serial_pkg`:
  - Parity encodings `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`.
  - TX and RX state enums.
  - `OVERSAMPLE`=16 and `MID_TICK`=8.
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`; ports push/pop/full/empty/head), instantiated once for RX and once for TX.
- The TX FSM, RX FSM and tick counters stay in the top level.

## Test plan
- Reset: hold `reset_i`=0 for 5 cycles → `tx_o`=1, `cmdfifo_txe`=1, `cmdfifo_rxf`=0, all flags 0.
- TX 0xA5, 8N1, `baud_div_i`=0:
  - Pulse `cmdfifo_wr` at cycle 0 → `tx_o` low over cycles 2–17.
  - Then 1,0,1,0,0,1,0,1 at 16 cycles each.
  - Stop bit high, `tx_busy` low at cycle 162.
- Loopback `tx_o`→`rx_i`, even parity, `stop2_i`=1, `baud_div_i`=3; write 0x00, 0xFF, 0x5A → `cmdfifo_din` reads 0x00, 0xFF, 0x5A in order, no flags.
- `RX_DEPTH`=4: inject 5 valid frames without `cmdfifo_rd` → 4 bytes retained in order, fifth dropped, `rx_overrun`=1. Pulse `err_clr_i` → 0.
- Odd parity: inject 0x01 with parity bit 1 → no push, `rx_parity_err`=1. Inject a frame with stop=0 → `rx_frame_err`=1.
- `TX_DEPTH`=16: `cmdfifo_wr` for 18 consecutive cycles from idle → 17 bytes accepted (1 in shifter, 16 in FIFO), `cmdfifo_txe`=0, 18th dropped, `tx_overflow`=1.
